bram_frame_streamer: RTL and testbench

Reads a processed frame out of BRAM1 through its second port and emits it as a pixel stream with valid/ready handshake and frame/line markers. It is the consumer side of the Sobel FSM's BRAM1 write path: started by that FSM's `o_done` pulse, it reads the linear, compacted image and delivers it downstream (display/UART/DMA). Its 2-entry output buffer absorbs the one-cycle BRAM read latency, so backpressure never loses or duplicates a pixel.

---
 rtl/bram_frame_streamer.sv | 194 +++++++++++++++++++
 tb/tb_bram_frame_streamer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_frame_streamer.sv
// bram_frame_streamer: reads a compacted frame from BRAM1 port 2 and emits it as a
// valid/ready pixel stream with sof/eol/eof markers.
// Build macro FRAME_STREAMER_PAD_EN: Sobel frames are emitted full-size with a zero border.
module bram_frame_streamer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 100,
  parameter int unsigned IMAGE_HEIGHT = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_run,
  output logic                  b1_ce2,
  output logic                  b1_we2,
  output logic [ADDR_WIDTH-1:0] b1_addr2,
  output logic [DATA_WIDTH-1:0] b1_d2,
  input  logic [DATA_WIDTH-1:0] b1_q2,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_eof,
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int unsigned XW = $clog2(IMAGE_WIDTH + 1);
  localparam int unsigned YW = $clog2(IMAGE_HEIGHT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         out_w_q, out_w_d, ix_q, ix_d, x_q, x_d;
  logic [YW-1:0]         out_h_q, out_h_d, iy_q, iy_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pend_q, pend_d, pend_zero_q, pend_zero_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
`ifdef FRAME_STREAMER_PAD_EN
  logic                  pad_q, pad_d;
`endif

  logic       pop, issue, issue_last, last_pix, border;
  logic [2:0] occ;

  // Handshake, read-issue and position decode from current state
  always_comb begin
    pop        = (count_q != 2'd0) && i_ready;
    occ        = 3'(count_q) + 3'(pend_q) - 3'(pop);
    issue      = (state_q == STREAM) && (occ < 3'd2);
    issue_last = (ix_q == out_w_q - XW'(1)) && (iy_q == out_h_q - YW'(1));
    last_pix   = (x_q == out_w_q - XW'(1)) && (y_q == out_h_q - YW'(1));
`ifdef FRAME_STREAMER_PAD_EN
    border     = pad_q && ((ix_q == '0) || (iy_q == '0) ||
                           (ix_q == out_w_q - XW'(1)) || (iy_q == out_h_q - YW'(1)));
`else
    border     = 1'b0;
`endif
  end

  assign b1_ce2   = issue && !border;
  assign b1_we2   = 1'b0;
  assign b1_addr2 = addr_q;
  assign b1_d2    = '0;
  assign o_valid  = (count_q != 2'd0);
  assign o_data   = fifo_q[rd_ptr_q];
  assign o_sof    = o_valid && (x_q == '0) && (y_q == '0);
  assign o_eol    = o_valid && (x_q == out_w_q - XW'(1));
  assign o_eof    = o_eol && (y_q == out_h_q - YW'(1));
  assign o_idle   = (state_q == IDLE);
  assign o_busy   = (state_q == STREAM) || (state_q == DRAIN);
  assign o_done   = (state_q == DONE);

  // Next-state, read issue, FIFO push/pop and output position counters
  always_comb begin
    state_d     = state_q;
    out_w_d     = out_w_q;
    out_h_d     = out_h_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    pend_d      = issue;
    pend_zero_d = issue && border;
    fifo_d[0]   = fifo_q[0];
    fifo_d[1]   = fifo_q[1];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = occ[1:0];
`ifdef FRAME_STREAMER_PAD_EN
    pad_d       = pad_q;
`endif

    // a border slot occupies a FIFO entry like a read but pushes zero
    if (pend_q) begin
      fifo_d[wr_ptr_q] = pend_zero_q ? '0 : b1_q2;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (x_q == out_w_q - XW'(1)) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    if (issue) begin
      if (!border) addr_d = addr_q + ADDR_WIDTH'(1);
      if (ix_q == out_w_q - XW'(1)) begin
        ix_d = '0;
        iy_d = iy_q + YW'(1);
      end else begin
        ix_d = ix_q + XW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = STREAM;
`ifdef FRAME_STREAMER_PAD_EN
          pad_d   = i_run;
          out_w_d = XW'(IMAGE_WIDTH);
          out_h_d = YW'(IMAGE_HEIGHT);
`else
          out_w_d = i_run ? XW'(IMAGE_WIDTH - 2) : XW'(IMAGE_WIDTH);
          out_h_d = i_run ? YW'(IMAGE_HEIGHT - 2) : YW'(IMAGE_HEIGHT);
`endif
          addr_d  = '0;
          ix_d    = '0;
          iy_d    = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      STREAM:  if (issue && issue_last) state_d = DRAIN;
      DRAIN:   if (pop && last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_w_q     <= '0;
      out_h_q     <= '0;
      ix_q        <= '0;
      iy_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_zero_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
`ifdef FRAME_STREAMER_PAD_EN
      pad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_w_q     <= out_w_d;
      out_h_q     <= out_h_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_zero_q <= pend_zero_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef FRAME_STREAMER_PAD_EN
      pad_q       <= pad_d;
`endif
    end
  end

endmodule

// File: tb/tb_bram_frame_streamer.sv
// tb_bram_frame_streamer: random stimulus against a frame-level reference model (4x4 frame).
`timescale 1ns/1ps
module tb_bram_frame_streamer;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          bram;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_run = 1'b0;
  logic          i_ready = 1'b1;
  logic          b1_ce2, b1_we2;
  logic [AW-1:0] b1_addr2;
  logic [DW-1:0] b1_d2;
  logic [DW-1:0] b1_q2 = '0;
  logic          o_valid, o_sof, o_eol, o_eof, o_idle, o_busy, o_done;
  logic [DW-1:0] o_data;

  logic [DW-1:0] mem [256];
  pix_t          exp_q [$];
  int            vectors = 0;
  int            miscompares = 0;
  int            exp_addr, rd_out;

  bram_frame_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_run(i_run),
    .b1_ce2(b1_ce2), .b1_we2(b1_we2), .b1_addr2(b1_addr2), .b1_d2(b1_d2), .b1_q2(b1_q2),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // BRAM1 port 2: one-cycle registered read
  always @(posedge clk) if (b1_ce2) b1_q2 <= mem[b1_addr2[7:0]];

  // Reference: the whole expected pixel stream of one frame, built from position rules
  task automatic load_expected(input bit run, output int n);
    int fw, fh, a;
    bit pad, brd;
    pix_t p;
    pad = 1'b0;
`ifdef FRAME_STREAMER_PAD_EN
    pad = run;
`endif
    fw = (run && !pad) ? W - 2 : W;
    fh = (run && !pad) ? H - 2 : H;
    exp_q.delete();
    a = 0;
    for (int y = 0; y < fh; y++) begin
      for (int x = 0; x < fw; x++) begin
        brd    = pad && (x == 0 || y == 0 || x == fw - 1 || y == fh - 1);
        p.data = brd ? '0 : mem[a];
        p.bram = !brd;
        if (!brd) a++;
        p.sof  = (x == 0) && (y == 0);
        p.eol  = (x == fw - 1);
        p.eof  = (x == fw - 1) && (y == fh - 1);
        exp_q.push_back(p);
      end
    end
    n = fw * fh;
  endtask

  // Drives one frame and scoreboards reads, pixels, markers and stall-hold every cycle
  task automatic run_frame(input bit run, input int rmode, input int restart_at,
                           input int reset_after, output int n_pix, output int first_valid,
                           output int done_at, output int dones);
    bit   stalled, pop, pop_b;
    pix_t held;
    int   pops;
    load_expected(run, n_pix);
    exp_addr = 0; rd_out = 0; stalled = 0; pops = 0;
    first_valid = -1; done_at = -1; dones = 0;
    held = '0;
    @(posedge clk); #1;
    i_start = 1'b1; i_run = run; i_ready = 1'b1;
    for (int cyc = 1; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      i_start = (cyc == restart_at);
      if (cyc == restart_at) i_run = ~run;
      case (rmode)
        0:       i_ready = 1'b1;
        1:       i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      pop   = o_valid && i_ready;
      pop_b = pop && (exp_q.size() > 0) && exp_q[0].bram;
      if (b1_ce2) begin
        vectors++;
        if (b1_addr2 !== AW'(exp_addr)) begin
          miscompares++;
          $display("FAIL read_addr cyc %0d: got %0d expected %0d", cyc, b1_addr2, exp_addr);
        end
        vectors++;
        if (rd_out - int'(pop_b) >= 2) begin
          miscompares++;
          $display("FAIL overflow cyc %0d: read issued with %0d in flight, required < 2", cyc, rd_out - int'(pop_b));
        end
        exp_addr++;
      end
      if (stalled) begin
        vectors++;
        if ({o_valid, o_data, o_sof, o_eol, o_eof} !== {1'b1, held.data, held.sof, held.eol, held.eof}) begin
          miscompares++;
          $display("FAIL stall_hold cyc %0d: got v%0b d%0h m%0b%0b%0b expected v1 d%0h m%0b%0b%0b", cyc,
                   o_valid, o_data, o_sof, o_eol, o_eof, held.data, held.sof, held.eol, held.eof);
        end
      end
      if (o_valid) begin
        if (first_valid < 0) first_valid = cyc;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_pixel cyc %0d: got d%0h expected no pixel", cyc, o_data);
        end else if ({o_data, o_sof, o_eol, o_eof} !== {exp_q[0].data, exp_q[0].sof, exp_q[0].eol, exp_q[0].eof}) begin
          miscompares++;
          $display("FAIL pixel %0d: got d%0h sof%0b eol%0b eof%0b expected d%0h sof%0b eol%0b eof%0b", pops,
                   o_data, o_sof, o_eol, o_eof, exp_q[0].data, exp_q[0].sof, exp_q[0].eol, exp_q[0].eof);
        end
        if (pop && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
      stalled   = o_valid && !i_ready;
      held.data = o_data; held.sof = o_sof; held.eol = o_eol; held.eof = o_eof;
      if (pop_b) rd_out--;
      if (b1_ce2) rd_out++;
      if (o_done) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      if (reset_after > 0 && pops == reset_after) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_valid, o_idle, o_busy, b1_ce2} !== 4'b0100) begin
          miscompares++;
          $display("FAIL reset_mid: got valid%0b idle%0b busy%0b ce%0b expected 0 1 0 0", o_valid, o_idle, o_busy, b1_ce2);
        end
        exp_q.delete();
        return;
      end
      if (done_at >= 0 && cyc >= done_at + 4) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({o_valid, o_data, o_sof, o_eol, o_eof} !== {1'b0, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_stream: got v%0b d%0h m%0b%0b%0b expected all 0", o_valid, o_data, o_sof, o_eol, o_eof);
    end
    vectors++;
    if ({b1_ce2, b1_we2, b1_addr2, b1_d2} !== {2'b00, 16'h0000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_bram: got ce%0b we%0b a%0h d%0h expected all 0", b1_ce2, b1_we2, b1_addr2, b1_d2);
    end
    vectors++;
    if ({o_idle, o_busy, o_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_status: got idle%0b busy%0b done%0b expected 1 0 0", o_idle, o_busy, o_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int n, fv, da, dn;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a);
    run_frame(1'b0, 0, -1, 0, n, fv, da, dn);
    vectors++;
    if (fv != 3) begin miscompares++; $display("FAIL full_latency: got %0d expected 3", fv); end
    vectors++;
    if (da != n + 3) begin miscompares++; $display("FAIL full_done_cycle: got %0d expected %0d", da, n + 3); end
    vectors++;
    if (dn != 1) begin miscompares++; $display("FAIL full_done_count: got %0d expected 1", dn); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL full_missing: got %0d left expected 0", exp_q.size()); end
    vectors++;
    if (o_idle !== 1'b1) begin miscompares++; $display("FAIL full_idle: got %0b expected 1", o_idle); end
  endtask

  task automatic test_sobel_frame();
    int n, fv, da, dn;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a + 10);
    run_frame(1'b1, 0, -1, 0, n, fv, da, dn);
    vectors++;
    if (fv != 3) begin miscompares++; $display("FAIL sobel_latency: got %0d expected 3", fv); end
    vectors++;
    if (da != n + 3) begin miscompares++; $display("FAIL sobel_done_cycle: got %0d expected %0d", da, n + 3); end
    vectors++;
    if (dn != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sobel_complete: got %0d dones %0d left expected 1 dones 0 left", dn, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n, fv, da, dn;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a);
    run_frame(1'b0, 1, -1, 0, n, fv, da, dn);
    vectors++;
    if (dn != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL backpressure: got %0d dones %0d left expected 1 dones 0 left", dn, exp_q.size());
    end
  endtask

  task automatic test_restart_ignored();
    int n, fv, da, dn;
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    run_frame(1'b0, 0, 8, 0, n, fv, da, dn);
    vectors++;
    if (dn != 1 || exp_q.size() != 0 || da != n + 3) begin
      miscompares++;
      $display("FAIL restart_ignored: got %0d dones at %0d, %0d left expected 1 done at %0d, 0 left", dn, da, exp_q.size(), n + 3);
    end
  endtask

  task automatic test_reset_midstream();
    int n, fv, da, dn;
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    run_frame(1'b0, 0, -1, 5, n, fv, da, dn);
    run_frame(1'b0, 0, -1, 0, n, fv, da, dn);
    vectors++;
    if (fv != 3 || dn != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_restart: got latency %0d dones %0d left %0d expected 3 1 0", fv, dn, exp_q.size());
    end
  endtask

  task automatic test_random();
    int n, fv, da, dn;
    bit run;
    for (int f = 0; f < 6; f++) begin
      for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
      run = 1'($urandom_range(0, 1));
      run_frame(run, 2, -1, 0, n, fv, da, dn);
      vectors++;
      if (dn != 1 || exp_q.size() != 0 || o_idle !== 1'b1) begin
        miscompares++;
        $display("FAIL random_frame %0d: got %0d dones %0d left idle%0b expected 1 0 1", f, dn, exp_q.size(), o_idle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sobel_frame();
    test_backpressure();
    test_restart_ignored();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
